// File: rtl/vector_mem_sequencer_if.sv
// Pipeline-side request/response bundle and memory-port bundle for the
// vector load/store sequencer.
interface vmem_req_if #(
   parameter int LANES  = 8,
   parameter int LANE_W = 32,
   parameter int ADDR_W = 32
);
   localparam int VEC_W = LANES * LANE_W;

   logic              req_valid;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [VEC_W-1:0]  req_wdata;
   logic [LANES-1:0]  req_mask;
   logic              stall;
   logic              done;
   logic [VEC_W-1:0]  rdata;

   modport master (output req_valid, req_we, req_addr, req_wdata, req_mask,
                   input  stall, done, rdata);
   modport slave  (input  req_valid, req_we, req_addr, req_wdata, req_mask,
                   output stall, done, rdata);
endinterface

interface vmem_bus_if #(
   parameter int MEM_W  = 32,
   parameter int ADDR_W = 32
);
   localparam int BPB = MEM_W / 8;

   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [BPB-1:0]    mem_be;
   logic [MEM_W-1:0]  mem_wdata;
   logic [MEM_W-1:0]  mem_rdata;

   modport master (output mem_addr, mem_we, mem_be, mem_wdata, input mem_rdata);
   modport slave  (input mem_addr, mem_we, mem_be, mem_wdata, output mem_rdata);
endinterface

// File: rtl/vector_mem_sequencer.sv
// Vector load/store sequencer: moves one VEC_W-bit register image to or from a
// MEM_W-bit synchronous RAM as a burst of beats, stalling the pipeline meanwhile.
module vector_mem_sequencer #(
   parameter int LANES  = 8,
   parameter int LANE_W = 32,
   parameter int MEM_W  = 32,
   parameter int ADDR_W = 32
) (
   input logic        clk,
   input logic        reset,
   vmem_req_if.slave  req,
   vmem_bus_if.master mem
);
   localparam int VEC_W  = LANES * LANE_W;
   localparam int BEATS  = VEC_W / MEM_W;
   localparam int LPB    = MEM_W / LANE_W;
   localparam int BPB    = MEM_W / 8;
   localparam int LANE_B = LANE_W / 8;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BEATS - 1);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BPB - 1);
   localparam logic [VEC_W-1:0]  SLICE_ONES = VEC_W'({MEM_W{1'b1}});

   typedef enum logic [2:0] {IDLE, STORE, LOAD, LDRAIN, LDONE} state_t;

   state_t            state, state_nx;
   logic [BEAT_W-1:0] beat, cap_idx;
   logic [ADDR_W-1:0] base_q, addr_hold, beat_addr;
   logic [VEC_W-1:0]  wdata_q, rdata_q;
   logic [LANES-1:0]  mask_q;
   logic [LPB-1:0]    beat_mask;
   logic [BPB-1:0]    beat_be;
   logic [MEM_W-1:0]  beat_wdata;
   logic              bursting, last, capture;

   assign bursting   = (state == STORE) || (state == LOAD);
   assign last       = (beat == LAST_BEAT);
   assign beat_addr  = base_q + ADDR_W'(beat) * ADDR_W'(BPB);
   assign beat_wdata = MEM_W'(wdata_q >> (MEM_W * beat));
   assign beat_mask  = LPB'(mask_q >> (LPB * beat));

   for (genvar l = 0; l < LPB; l++) begin : g_be
      assign beat_be[l*LANE_B +: LANE_B] = {LANE_B{beat_mask[l]}};
   end

   // The RAM returns a beat one cycle late, so each LOAD cycle after the
   // first stores the previous beat; LDRAIN picks up the final one.
   assign capture = ((state == LOAD) && (beat != '0)) || (state == LDRAIN);
   assign cap_idx = (state == LDRAIN) ? LAST_BEAT : beat - BEAT_W'(1);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         beat      <= '0;
         base_q    <= '0;
         wdata_q   <= '0;
         mask_q    <= '0;
         rdata_q   <= '0;
         addr_hold <= '0;
      end else begin
         state <= state_nx;
         beat  <= (bursting && !last) ? beat + BEAT_W'(1) : '0;
         if (state == IDLE && req.req_valid) begin
            base_q  <= req.req_addr & ALIGN_MASK;
            wdata_q <= req.req_wdata;
            mask_q  <= req.req_mask;
         end
         if (bursting)
            addr_hold <= beat_addr;
         if (capture)
            rdata_q <= (rdata_q & ~(SLICE_ONES << (MEM_W * cap_idx)))
                     | (VEC_W'(mem.mem_rdata) << (MEM_W * cap_idx));
      end
   end

   // NOTE: every output and the next state get a default before the case so
   // no path through this block leaves a value unassigned (no latches).
   always_comb begin
      state_nx      = state;
      req.stall     = 1'b0;
      req.done      = 1'b0;
      mem.mem_we    = 1'b0;
      mem.mem_be    = '0;
      mem.mem_wdata = '0;
      mem.mem_addr  = addr_hold;
      case (state)
         IDLE: begin
            if (req.req_valid) begin
               req.stall = 1'b1;
               state_nx  = req.req_we ? STORE : LOAD;
            end
         end
         STORE: begin
            mem.mem_we    = 1'b1;
            mem.mem_be    = beat_be;
            mem.mem_wdata = beat_wdata;
            mem.mem_addr  = beat_addr;
            if (last) begin
               req.done = 1'b1;
               state_nx = IDLE;
            end else begin
               req.stall = 1'b1;
            end
         end
         LOAD: begin
            mem.mem_addr = beat_addr;
            req.stall    = 1'b1;
            if (last)
               state_nx = LDRAIN;
         end
         LDRAIN: begin
            req.stall = 1'b1;
            state_nx  = LDONE;
         end
         LDONE: begin
            req.done = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign req.rdata = rdata_q;
endmodule
